// File: rtl/csr_bus_initiator.sv
// Single-outstanding CSR bus initiator: turns a valid/ready command into a one-cycle
// access request, waits for the matching ack (or times out) and holds the response until taken.
module csr_bus_initiator #(
    parameter int WORD_BIT_WIDTH      = 32,
    parameter int BYTE_ADDR_BIT_WIDTH = 8,
    parameter int TIMEOUT_CYCLES      = 16
) (
    input  logic                           i_clk,
    input  logic                           i_async_rst_n,
    input  logic                           i_cmd_valid,
    output logic                           o_cmd_ready,
    input  logic                           i_cmd_is_wr,
    input  logic [BYTE_ADDR_BIT_WIDTH-1:0] i_cmd_byte_addr,
    input  logic [WORD_BIT_WIDTH-1:0]      i_cmd_wr_data,
    input  logic [WORD_BIT_WIDTH-1:0]      i_cmd_wr_bit_en,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [WORD_BIT_WIDTH-1:0]      o_rsp_rd_data,
    output logic                           o_rsp_err,
    output logic                           o_acc_req,
    output logic                           o_acc_req_is_wr,
    output logic [BYTE_ADDR_BIT_WIDTH-1:0] o_byte_addr,
    output logic [WORD_BIT_WIDTH-1:0]      o_wr_data,
    output logic [WORD_BIT_WIDTH-1:0]      o_wr_bit_en,
    input  logic                           i_rd_ack,
    input  logic [WORD_BIT_WIDTH-1:0]      i_rd_data,
    input  logic                           i_wr_ack
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    generate
        if (WORD_BIT_WIDTH < 8 || (WORD_BIT_WIDTH & (WORD_BIT_WIDTH - 1)) != 0) begin : g_bad_word
            $error("csr_bus_initiator: WORD_BIT_WIDTH must be a power of 2 and >= 8");
        end
        if (BYTE_ADDR_BIT_WIDTH < 1) begin : g_bad_addr
            $error("csr_bus_initiator: BYTE_ADDR_BIT_WIDTH must be >= 1");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("csr_bus_initiator: TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RSP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             ack_match;

    // The ack line that counts depends on the held command type; the other one is ignored.
    assign ack_match = o_acc_req_is_wr ? i_wr_ack : i_rd_ack;

    // NOTE: all state and outputs here are flops, so every assignment is non-blocking;
    // later assignments in the same cycle override earlier defaults without ordering hazards.
    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            o_cmd_ready     <= 1'b0;
            o_acc_req       <= 1'b0;
            o_acc_req_is_wr <= 1'b0;
            o_byte_addr     <= '0;
            o_wr_data       <= '0;
            o_wr_bit_en     <= '0;
            o_rsp_valid     <= 1'b0;
            o_rsp_err       <= 1'b0;
            o_rsp_rd_data   <= '0;
        end else begin
            o_acc_req <= 1'b0;
            case (state)
                IDLE: begin
                    o_cmd_ready <= 1'b1;
                    if (i_cmd_valid && o_cmd_ready) begin
                        o_cmd_ready     <= 1'b0;
                        o_acc_req       <= 1'b1;
                        o_acc_req_is_wr <= i_cmd_is_wr;
                        o_byte_addr     <= i_cmd_byte_addr;
                        o_wr_data       <= i_cmd_wr_data;
                        o_wr_bit_en     <= i_cmd_wr_bit_en;
                        wait_cnt        <= '0;
                        state           <= REQ;
                    end
                end
                REQ, WAIT: begin
                    if (ack_match) begin
                        state         <= RSP;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_err     <= 1'b0;
                        o_rsp_rd_data <= o_acc_req_is_wr ? '0 : i_rd_data;
                    end else if (state == REQ) begin
                        state <= WAIT;
                    end else if (wait_cnt == LAST_WAIT) begin
                        // Last permitted WAIT cycle passed without a matching ack.
                        state         <= RSP;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_err     <= 1'b1;
                        o_rsp_rd_data <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RSP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_cmd_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_bus_initiator.sv
// Scoreboard bench for csr_bus_initiator: the stimulus pushes expected requests and responses,
// an independent negedge monitor pops and compares them as the DUT presents them.
module tb_csr_bus_initiator;

    localparam int W = 32;
    localparam int A = 8;
    localparam int T = 4;

    logic          i_clk;
    logic          i_async_rst_n;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_is_wr;
    logic [A-1:0]  i_cmd_byte_addr;
    logic [W-1:0]  i_cmd_wr_data;
    logic [W-1:0]  i_cmd_wr_bit_en;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [W-1:0]  o_rsp_rd_data;
    logic          o_rsp_err;
    logic          o_acc_req;
    logic          o_acc_req_is_wr;
    logic [A-1:0]  o_byte_addr;
    logic [W-1:0]  o_wr_data;
    logic [W-1:0]  o_wr_bit_en;
    logic          i_rd_ack;
    logic [W-1:0]  i_rd_data;
    logic          i_wr_ack;

    csr_bus_initiator #(
        .WORD_BIT_WIDTH     (W),
        .BYTE_ADDR_BIT_WIDTH(A),
        .TIMEOUT_CYCLES     (T)
    ) dut (
        .i_clk          (i_clk),
        .i_async_rst_n  (i_async_rst_n),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_is_wr    (i_cmd_is_wr),
        .i_cmd_byte_addr(i_cmd_byte_addr),
        .i_cmd_wr_data  (i_cmd_wr_data),
        .i_cmd_wr_bit_en(i_cmd_wr_bit_en),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_rd_data  (o_rsp_rd_data),
        .o_rsp_err      (o_rsp_err),
        .o_acc_req      (o_acc_req),
        .o_acc_req_is_wr(o_acc_req_is_wr),
        .o_byte_addr    (o_byte_addr),
        .o_wr_data      (o_wr_data),
        .o_wr_bit_en    (o_wr_bit_en),
        .i_rd_ack       (i_rd_ack),
        .i_rd_data      (i_rd_data),
        .i_wr_ack       (i_wr_ack)
    );

    typedef struct {
        logic         is_wr;
        logic [A-1:0] addr;
        logic [W-1:0] data;
        logic [W-1:0] ben;
    } req_t;

    typedef struct {
        logic         err;
        logic [W-1:0] data;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: an ack k cycles after the request (k=0 is the request cycle itself) succeeds
    // when k <= T; otherwise the initiator reports a timeout with zero data.
    function automatic rsp_t model_rsp(input logic is_wr, input int ack_k, input logic [W-1:0] rd_val);
        rsp_t r;
        if (ack_k <= T) begin
            r.err  = 1'b0;
            r.data = is_wr ? '0 : rd_val;
        end else begin
            r.err  = 1'b1;
            r.data = '0;
        end
        return r;
    endfunction

    function automatic int model_latency(input int ack_k);
        return (ack_k <= T) ? ack_k + 1 : T + 1;
    endfunction

    // Monitor: compares every access request and every response handshake against the queues.
    initial begin
        req_t         cur;
        rsp_t         exp;
        logic         prev_acc;
        logic         prev_valid;
        logic         prev_hs;
        logic         prev_err;
        logic [W-1:0] prev_data;
        prev_acc   = 1'b0;
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        prev_err   = 1'b0;
        prev_data  = '0;
        cur        = '{1'b0, '0, '0, '0};
        forever begin
            @(negedge i_clk);
            if (!i_async_rst_n) begin
                prev_acc   = 1'b0;
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
                continue;
            end
            if (o_acc_req) begin
                check("acc_req_single_pulse", prev_acc, 1'b0);
                if (req_q.size() == 0) begin
                    check("acc_req_unexpected", 1'b1, 1'b0);
                end else begin
                    cur = req_q.pop_front();
                    check("req_is_wr", o_acc_req_is_wr, cur.is_wr);
                    check("req_addr", o_byte_addr, cur.addr);
                    check("req_wr_data", o_wr_data, cur.data);
                    check("req_wr_bit_en", o_wr_bit_en, cur.ben);
                end
            end
            if (o_rsp_valid) begin
                check("cmd_ready_low_in_rsp", o_cmd_ready, 1'b0);
                if (prev_valid && !prev_hs) begin
                    check("rsp_err_held", o_rsp_err, prev_err);
                    check("rsp_data_held", o_rsp_rd_data, prev_data);
                end
                if (i_rsp_ready) begin
                    if (rsp_q.size() == 0) begin
                        check("rsp_unexpected", 1'b1, 1'b0);
                    end else begin
                        exp = rsp_q.pop_front();
                        check("rsp_err", o_rsp_err, exp.err);
                        check("rsp_rd_data", o_rsp_rd_data, exp.data);
                        check("req_addr_held", o_byte_addr, cur.addr);
                        check("req_wr_data_held", o_wr_data, cur.data);
                    end
                end
            end
            prev_acc   = o_acc_req;
            prev_valid = o_rsp_valid;
            prev_hs    = o_rsp_valid && i_rsp_ready;
            prev_err   = o_rsp_err;
            prev_data  = o_rsp_rd_data;
        end
    end

    task automatic clear_acks();
        i_rd_ack    = 1'b0;
        i_wr_ack    = 1'b0;
        i_rsp_ready = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            i_rd_ack  = 1'($urandom_range(0, 1));
            i_wr_ack  = 1'($urandom_range(0, 1));
            i_rd_data = $urandom;
            @(posedge i_clk);
            #1;
        end
        clear_acks();
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!o_cmd_ready && n < 50) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        ok = o_cmd_ready;
        if (!ok) check("cmd_ready_wait", 1'b0, 1'b1);
    endtask

    // One full transaction. The responder acks ack_k cycles after the request; wrong_ack drives
    // the other ack line while pending; late_ack drives both acks during the response phase.
    task automatic run_txn(input logic is_wr, input logic [A-1:0] addr, input logic [W-1:0] data,
                           input logic [W-1:0] ben, input logic [W-1:0] rd_val, input int ack_k,
                           input logic wrong_ack, input logic late_ack, input int stall);
        bit ok;
        bit done;
        int first;
        wait_ready(ok);
        if (!ok) return;
        req_q.push_back('{is_wr, addr, data, ben});
        rsp_q.push_back(model_rsp(is_wr, ack_k, rd_val));
        i_cmd_valid     = 1'b1;
        i_cmd_is_wr     = is_wr;
        i_cmd_byte_addr = addr;
        i_cmd_wr_data   = data;
        i_cmd_wr_bit_en = ben;
        i_rd_ack        = 1'($urandom_range(0, 1));
        i_wr_ack        = 1'($urandom_range(0, 1));
        i_rd_data       = $urandom;
        @(posedge i_clk);
        #1;
        i_cmd_valid     = 1'b0;
        i_cmd_is_wr     = 1'($urandom_range(0, 1));
        i_cmd_byte_addr = A'($urandom);
        i_cmd_wr_data   = $urandom;
        i_cmd_wr_bit_en = $urandom;
        first = -1;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c == 0) check("acc_req_latency", o_acc_req, 1'b1);
            i_rd_ack  = 1'b0;
            i_wr_ack  = 1'b0;
            i_rd_data = $urandom;
            if (c == ack_k) begin
                if (is_wr) begin
                    i_wr_ack = 1'b1;
                end else begin
                    i_rd_ack  = 1'b1;
                    i_rd_data = rd_val;
                end
            end
            if (wrong_ack && !o_rsp_valid) begin
                if (is_wr) i_rd_ack = 1'b1;
                else       i_wr_ack = 1'b1;
            end
            if (late_ack && o_rsp_valid) begin
                i_rd_ack = 1'b1;
                i_wr_ack = 1'b1;
            end
            if (o_rsp_valid && first < 0) first = c;
            i_rsp_ready = o_rsp_valid && (stall == 0);
            if (o_rsp_valid && stall > 0) stall--;
            done = o_rsp_valid && i_rsp_ready;
            @(posedge i_clk);
            #1;
        end
        clear_acks();
        if (!done) check("rsp_never_completed", 1'b0, 1'b1);
        check("rsp_latency", 64'(first), 64'(model_latency(ack_k)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_acc_req"}, o_acc_req, 1'b0);
        check({tag, "_rsp_valid"}, o_rsp_valid, 1'b0);
        check({tag, "_rsp_err"}, o_rsp_err, 1'b0);
        check({tag, "_rsp_rd_data"}, o_rsp_rd_data, '0);
        check({tag, "_is_wr"}, o_acc_req_is_wr, 1'b0);
        check({tag, "_byte_addr"}, o_byte_addr, '0);
        check({tag, "_wr_data"}, o_wr_data, '0);
        check({tag, "_wr_bit_en"}, o_wr_bit_en, '0);
    endtask

    initial begin
        bit           ok;
        logic         r_wr;
        logic         r_wrong;
        logic         r_late;
        logic [A-1:0] r_addr;
        logic [W-1:0] r_data;
        logic [W-1:0] r_ben;
        logic [W-1:0] r_rd;
        int           r_k;
        int           r_stall;

        i_async_rst_n   = 1'b0;
        i_cmd_valid     = 1'b0;
        i_cmd_is_wr     = 1'b0;
        i_cmd_byte_addr = '0;
        i_cmd_wr_data   = '0;
        i_cmd_wr_bit_en = '0;
        i_rd_data       = '0;
        clear_acks();
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("reset");
        i_async_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("cmd_ready_after_reset", o_cmd_ready, 1'b1);

        // Directed cases: basic read/write, timeout boundary, wrong/late acks, backpressure.
        run_txn(1'b0, 8'h08, 32'h0, 32'h0, 32'hDEADBEEF, 1, 1'b0, 1'b0, 0);
        run_txn(1'b1, 8'h10, 32'h12345678, 32'h0000FFFF, 32'hA5A5A5A5, 1, 1'b0, 1'b0, 0);
        run_txn(1'b0, 8'h20, 32'h0, 32'h0, 32'h11112222, 99, 1'b0, 1'b0, 0);
        run_txn(1'b0, 8'h24, 32'h0, 32'h0, 32'hCAFEF00D, T, 1'b0, 1'b0, 0);
        run_txn(1'b1, 8'h28, 32'h55AA55AA, 32'hFFFF0000, 32'h0, T, 1'b0, 1'b0, 0);
        run_txn(1'b0, 8'h2C, 32'h0, 32'h0, 32'h33334444, T + 1, 1'b0, 1'b0, 0);
        run_txn(1'b0, 8'h30, 32'h0, 32'h0, 32'h0BADC0DE, 99, 1'b1, 1'b0, 0);
        run_txn(1'b1, 8'h34, 32'h87654321, 32'hFFFFFFFF, 32'h0, 99, 1'b1, 1'b0, 0);
        run_txn(1'b0, 8'h38, 32'h0, 32'h0, 32'h600DD00D, 2, 1'b1, 1'b1, 5);
        run_txn(1'b1, 8'h3C, 32'hF0F0F0F0, 32'h00FF00FF, 32'h0, 0, 1'b0, 1'b1, 5);
        run_txn(1'b0, 8'h03, 32'h0, 32'h0, 32'h76543210, 0, 1'b0, 1'b0, 0);
        run_txn(1'b1, 8'hFF, 32'hFFFFFFFF, 32'h80000001, 32'h0, 1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            r_wr    = 1'($urandom_range(0, 1));
            r_addr  = A'($urandom);
            r_data  = $urandom;
            r_ben   = $urandom;
            r_rd    = $urandom;
            r_k     = $urandom_range(0, T + 3);
            r_wrong = ($urandom_range(0, 3) == 0);
            r_late  = 1'($urandom_range(0, 1));
            r_stall = $urandom_range(0, 3);
            run_txn(r_wr, r_addr, r_data, r_ben, r_rd, r_k, r_wrong, r_late, r_stall);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end

        // Reset while waiting for an ack: the transaction must vanish without a response.
        wait_ready(ok);
        if (ok) begin
            req_q.push_back('{1'b1, 8'h44, 32'h13579BDF, 32'h0F0F0F0F});
            i_cmd_valid     = 1'b1;
            i_cmd_is_wr     = 1'b1;
            i_cmd_byte_addr = 8'h44;
            i_cmd_wr_data   = 32'h13579BDF;
            i_cmd_wr_bit_en = 32'h0F0F0F0F;
            @(posedge i_clk);
            #1;
            i_cmd_valid = 1'b0;
            repeat (2) @(posedge i_clk);
            #3;
            i_async_rst_n = 1'b0;
            #1;
            check_reset_outputs("abort");
            i_rd_ack  = 1'b1;
            i_wr_ack  = 1'b1;
            i_rd_data = 32'hFEEDFACE;
            repeat (2) @(posedge i_clk);
            #1;
            i_async_rst_n = 1'b1;
            @(posedge i_clk);
            #1;
            check("cmd_ready_after_abort", o_cmd_ready, 1'b1);
            for (int i = 0; i < 4; i++) begin
                check("no_rsp_after_abort", o_rsp_valid, 1'b0);
                check("no_req_after_abort", o_acc_req, 1'b0);
                @(posedge i_clk);
                #1;
            end
            clear_acks();
        end

        run_txn(1'b0, 8'h48, 32'h0, 32'h0, 32'h24681357, 1, 1'b0, 1'b0, 0);
        repeat (3) @(posedge i_clk);
        #1;
        check("req_queue_drained", 64'(req_q.size()), 64'd0);
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_bus_initiator.md
CSR_BUS_INITIATOR -- requirements
Module: csr_bus_initiator

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WORD_BIT_WIDTH, 32, CSR data width; power of 2, >= 8
- BYTE_ADDR_BIT_WIDTH, 8, CSR byte address width
- TIMEOUT_CYCLES, 16, max ack-wait cycles after request; >= 1
REQ-002 Illegal parameter values SHALL cause an elaboration error.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- i_clk  in  1  clock
- i_async_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command ready
- i_cmd_is_wr  in  1  1: write, 0: read
- i_cmd_byte_addr  in  BYTE_ADDR_BIT_WIDTH  byte address
- i_cmd_wr_data  in  WORD_BIT_WIDTH  write data
- i_cmd_wr_bit_en  in  WORD_BIT_WIDTH  write bit enable
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response ready
- o_rsp_rd_data  out  WORD_BIT_WIDTH  read data (0 for writes/errors)
- o_rsp_err  out  1  1: timeout
- o_acc_req  out  1  CSR access request pulse
- o_acc_req_is_wr  out  1  CSR request is write
- o_byte_addr  out  BYTE_ADDR_BIT_WIDTH  CSR byte address
- o_wr_data  out  WORD_BIT_WIDTH  CSR write data
- o_wr_bit_en  out  WORD_BIT_WIDTH  CSR write bit enable
- i_rd_ack  in  1  CSR read acknowledge
- i_rd_data  in  WORD_BIT_WIDTH  CSR read data, valid with i_rd_ack
- i_wr_ack  in  1  CSR write acknowledge
REQ-004 One clock domain (i_clk); reset i_async_rst_n is asynchronous, active-low.

Function
REQ-005 FSM states SHALL be IDLE, REQ, WAIT, RSP; one transaction outstanding at most.
REQ-006 o_cmd_ready SHALL be 1 exactly when state is IDLE.
REQ-007 IDLE: on i_cmd_valid && o_cmd_ready, all command fields SHALL be registered and state SHALL go to REQ.
REQ-008 REQ: o_acc_req SHALL be 1 for exactly this one cycle; o_acc_req_is_wr, o_byte_addr, o_wr_data, o_wr_bit_en SHALL hold the registered command from REQ until the next accepted command.
REQ-009 Matching ack: i_rd_ack for reads, i_wr_ack for writes; non-matching ack SHALL be ignored.
REQ-010 Matching ack sampled in REQ or WAIT SHALL move state to RSP next cycle with o_rsp_err=0; for reads i_rd_data SHALL be captured into o_rsp_rd_data, for writes o_rsp_rd_data=0.
REQ-011 REQ without ack SHALL go to WAIT; a wait counter SHALL clear on entering REQ and increment per WAIT cycle, width $clog2(TIMEOUT_CYCLES+1).
REQ-012 If no matching ack by the TIMEOUT_CYCLES-th WAIT cycle, state SHALL go to RSP with o_rsp_err=1, o_rsp_rd_data=0.
REQ-013 Ack and timeout in the same cycle: ack SHALL win (o_rsp_err=0).
REQ-014 RSP: o_rsp_valid=1, response fields stable until i_rsp_ready; on handshake state SHALL go to IDLE; next command acceptable the following cycle.
REQ-015 Acks arriving in IDLE or RSP (late/spurious) SHALL be ignored and not alter held response.
REQ-016 Latency with 1-cycle responder: command handshake at cycle T -> o_acc_req at T+1 -> ack T+2 -> o_rsp_valid T+3.
REQ-017 Byte address SHALL pass unmodified (alignment is responder's concern).

Reset
REQ-018 While i_async_rst_n=0: state IDLE, counter 0, o_acc_req=0, o_rsp_valid=0, o_rsp_err=0, o_rsp_rd_data=0, command registers 0; o_cmd_ready=1 from the first clock edge after deassertion.
REQ-019 Reset asserted mid-transaction SHALL abort it with no response; acks after reset SHALL be ignored.

Verification
REQ-020 Read: cmd rd addr 0x08, responder acks 1 cycle later with 0xDEADBEEF -> o_acc_req single pulse, o_byte_addr=0x08, rsp err=0, rd_data=0xDEADBEEF at T+3.
REQ-021 Write: addr 0x10, data 0x12345678, bit_en 0x0000FFFF -> o_acc_req_is_wr=1, fields driven as given, rsp err=0, rd_data=0.
REQ-022 Timeout: TIMEOUT_CYCLES=4, no ack -> rsp err=1, rd_data=0 after 4 WAIT cycles; ack on 4th WAIT cycle -> err=0.
REQ-023 Wrong-type/late ack: i_wr_ack during read wait -> ignored, times out; ack in RSP -> response unchanged.
REQ-024 Backpressure: i_rsp_ready=0 for 5 cycles -> o_rsp_valid and data held, o_cmd_ready=0; back-to-back commands each produce exactly one o_acc_req pulse.
REQ-025 Reset in WAIT -> all outputs per REQ-018, no o_rsp_valid.
